// File: rtl/painterengine_gpu_reader_arbiter.sv
// painterengine_gpu_reader_arbiter
// Shares one GPU DMA reader between two requesters (ch0 = display streamer,
// ch1 = blitter/texture fetch). Whole transfers are granted, never split.
// A no-progress watchdog fails a stalled read so the display cannot starve.
//
// Ports
//   i_wire_clock / i_wire_resetn        clock, async active-low reset
//   i_wire_chN_address/_length/_resetn  requester start address, word count, request/hold
//   o_wire_chN_done/_error              completion flags, held until chN_resetn drops
//   o_wire_chN_data/_data_valid         reader data (broadcast) / beat for granted channel
//   i_wire_chN_data_next                requester can take a beat
//   o_wire_reader_*                     address/length/resetn/data_next to the DMA reader
//   i_wire_reader_*                     done/error/data/data_valid from the DMA reader
//   o_wire_state                        {16'd0, timeout_count, 3'd0, grant, 1'b0, state}
module painterengine_gpu_reader_arbiter #(
    parameter int PARAM_CH0_PRIORITY = 1,
    parameter int PARAM_TIMEOUT      = 4096
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic [31:0] i_wire_ch0_address,
    input  logic [31:0] i_wire_ch0_length,
    input  logic        i_wire_ch0_resetn,
    output logic        o_wire_ch0_done,
    output logic        o_wire_ch0_error,
    output logic [31:0] o_wire_ch0_data,
    output logic        o_wire_ch0_data_valid,
    input  logic        i_wire_ch0_data_next,
    input  logic [31:0] i_wire_ch1_address,
    input  logic [31:0] i_wire_ch1_length,
    input  logic        i_wire_ch1_resetn,
    output logic        o_wire_ch1_done,
    output logic        o_wire_ch1_error,
    output logic [31:0] o_wire_ch1_data,
    output logic        o_wire_ch1_data_valid,
    input  logic        i_wire_ch1_data_next,
    output logic [31:0] o_wire_reader_address,
    output logic [31:0] o_wire_reader_length,
    output logic        o_wire_reader_resetn,
    input  logic        i_wire_reader_done,
    input  logic        i_wire_reader_error,
    input  logic [31:0] i_wire_reader_data,
    input  logic        i_wire_reader_data_valid,
    output logic        o_wire_reader_data_next,
    output logic [31:0] o_wire_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_BUSY    = 3'd2,
        S_ZERO    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    // Watchdog fires on the PARAM_TIMEOUT-th consecutive beat-less BUSY cycle.
    localparam logic [15:0] WD_LAST = 16'(PARAM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        rr_q, rr_d;          // channel preferred on the next contended grant
    logic [31:0] addr_q, addr_d;
    logic [31:0] len_q, len_d;
    logic [15:0] wd_q, wd_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;

    logic [1:0]  req;
    logic        win;
    logic        g_req;
    logic        busy;

    assign req   = {i_wire_ch1_resetn, i_wire_ch0_resetn};
    assign g_req = grant_q ? i_wire_ch1_resetn : i_wire_ch0_resetn;
    assign busy  = (state_q == S_BUSY);

    always_comb begin
        win = 1'b0;
        if (req == 2'b10)
            win = 1'b1;
        else if (req == 2'b11)
            win = (PARAM_CH0_PRIORITY != 0) ? 1'b0 : rr_q;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wd_d    = wd_q;
        tcnt_d  = tcnt_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = win;
                    rr_d    = ~win;
                    addr_d  = win ? i_wire_ch1_address : i_wire_ch0_address;
                    len_d   = win ? i_wire_ch1_length  : i_wire_ch0_length;
                    state_d = (len_d == 32'd0) ? S_ZERO : S_ARM;
                end
            end
            S_ARM: begin
                wd_d    = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                // Abort beats everything: a released requester gets no flags.
                if (!g_req) begin
                    state_d = S_RELEASE;
                end else if (i_wire_reader_error) begin
                    err_d[grant_q] = 1'b1;
                    state_d        = S_RELEASE;
                end else if (i_wire_reader_done) begin
                    done_d[grant_q] = 1'b1;
                    state_d         = S_RELEASE;
                end else if (i_wire_reader_data_valid) begin
                    wd_d = '0;
                end else if (wd_q == WD_LAST) begin
                    err_d[grant_q] = 1'b1;
                    if (tcnt_q != 8'hff)
                        tcnt_d = tcnt_q + 8'd1;
                    state_d = S_RELEASE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_ZERO: begin
                done_d[grant_q] = 1'b1;
                state_d         = S_RELEASE;
            end
            S_RELEASE: begin
                if (!g_req) begin
                    done_d  = '0;
                    err_d   = '0;
                    grant_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            wd_q    <= '0;
            tcnt_q  <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wd_q    <= wd_d;
            tcnt_q  <= tcnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Reader is held in reset everywhere except BUSY, so ARM gives a
    // guaranteed one-cycle restart pulse.
    assign o_wire_reader_resetn    = busy;
    assign o_wire_reader_address   = addr_q;
    assign o_wire_reader_length    = len_q;
    assign o_wire_reader_data_next = busy & (grant_q ? i_wire_ch1_data_next : i_wire_ch0_data_next);

    assign o_wire_ch0_data       = busy ? i_wire_reader_data : 32'd0;
    assign o_wire_ch1_data       = busy ? i_wire_reader_data : 32'd0;
    assign o_wire_ch0_data_valid = busy & ~grant_q & i_wire_reader_data_valid;
    assign o_wire_ch1_data_valid = busy &  grant_q & i_wire_reader_data_valid;
    assign o_wire_ch0_done       = done_q[0];
    assign o_wire_ch1_done       = done_q[1];
    assign o_wire_ch0_error      = err_q[0];
    assign o_wire_ch1_error      = err_q[1];

    assign o_wire_state = {16'd0, tcnt_q, 3'd0, grant_q, 1'b0, state_q};

endmodule

// File: tb/tb_painterengine_gpu_reader_arbiter.sv
// Bench for painterengine_gpu_reader_arbiter. Two instances share the reader
// and address/length stimulus: instance 0 is round-robin, instance 1 is ch0
// priority; both use a 16-cycle watchdog. Requester handshakes are per instance.
module tb_painterengine_gpu_reader_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] ch_addr [2];
    logic [31:0] ch_len  [2];
    logic [1:0]  ch_rn   [2];
    logic [1:0]  ch_dn   [2];
    logic        rd_done, rd_error, rd_valid;
    logic [31:0] rd_data;

    logic        o_done0 [2], o_done1 [2], o_err0 [2], o_err1 [2];
    logic        o_dv0 [2], o_dv1 [2], r_rn [2], r_dn [2];
    logic [31:0] o_d0 [2], o_d1 [2], r_addr [2], r_len [2], st [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        painterengine_gpu_reader_arbiter #(
            .PARAM_CH0_PRIORITY(g),
            .PARAM_TIMEOUT(TO)
        ) u_dut (
            .i_wire_clock            (clk),
            .i_wire_resetn           (rstn),
            .i_wire_ch0_address      (ch_addr[0]),
            .i_wire_ch0_length       (ch_len[0]),
            .i_wire_ch0_resetn       (ch_rn[g][0]),
            .o_wire_ch0_done         (o_done0[g]),
            .o_wire_ch0_error        (o_err0[g]),
            .o_wire_ch0_data         (o_d0[g]),
            .o_wire_ch0_data_valid   (o_dv0[g]),
            .i_wire_ch0_data_next    (ch_dn[g][0]),
            .i_wire_ch1_address      (ch_addr[1]),
            .i_wire_ch1_length       (ch_len[1]),
            .i_wire_ch1_resetn       (ch_rn[g][1]),
            .o_wire_ch1_done         (o_done1[g]),
            .o_wire_ch1_error        (o_err1[g]),
            .o_wire_ch1_data         (o_d1[g]),
            .o_wire_ch1_data_valid   (o_dv1[g]),
            .i_wire_ch1_data_next    (ch_dn[g][1]),
            .o_wire_reader_address   (r_addr[g]),
            .o_wire_reader_length    (r_len[g]),
            .o_wire_reader_resetn    (r_rn[g]),
            .i_wire_reader_done      (rd_done),
            .i_wire_reader_error     (rd_error),
            .i_wire_reader_data      (rd_data),
            .i_wire_reader_data_valid(rd_valid),
            .o_wire_reader_data_next (r_dn[g]),
            .o_wire_state            (st[g])
        );
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 arm, 2 busy, 3 zero-length, 4 release
    logic [2:0]  m_phase [2];
    logic        m_grant [2], m_pref [2];
    logic [31:0] m_addr [2], m_len [2];
    int          m_stall [2];
    logic [7:0]  m_tcnt [2];
    logic [1:0]  m_done [2], m_err [2];

    task automatic model_reset(input int i);
        m_phase[i] = 3'd0; m_grant[i] = 1'b0; m_pref[i] = 1'b0;
        m_addr[i] = '0; m_len[i] = '0; m_stall[i] = 0; m_tcnt[i] = '0;
        m_done[i] = '0; m_err[i] = '0;
    endtask

    task automatic model_step(input int i);
        logic [1:0] req;
        logic       w, g, own;
        req = ch_rn[i];
        g   = m_grant[i];
        own = req[g];
        case (m_phase[i])
            3'd0: if (req != 2'b00) begin
                if (req == 2'b11) w = (i == 0) ? m_pref[i] : 1'b0;
                else              w = req[1];
                m_pref[i]  = ~w;
                m_grant[i] = w;
                m_addr[i]  = ch_addr[w];
                m_len[i]   = ch_len[w];
                m_phase[i] = (ch_len[w] == 0) ? 3'd3 : 3'd1;
            end
            3'd1: begin m_phase[i] = 3'd2; m_stall[i] = 0; end
            3'd2: begin
                if (!own) m_phase[i] = 3'd4;
                else if (rd_error) begin m_err[i][g] = 1'b1; m_phase[i] = 3'd4; end
                else if (rd_done) begin m_done[i][g] = 1'b1; m_phase[i] = 3'd4; end
                else begin
                    m_stall[i] = rd_valid ? 0 : m_stall[i] + 1;
                    if (m_stall[i] == TO) begin
                        m_err[i][g] = 1'b1;
                        if (m_tcnt[i] != 8'hff) m_tcnt[i] = m_tcnt[i] + 8'd1;
                        m_phase[i] = 3'd4;
                    end
                end
            end
            3'd3: begin m_done[i][g] = 1'b1; m_phase[i] = 3'd4; end
            default: if (!own) begin
                m_done[i] = '0; m_err[i] = '0; m_grant[i] = 1'b0; m_phase[i] = 3'd0;
            end
        endcase
    endtask

    always @(posedge clk)
        for (int i = 0; i < 2; i++)
            if (!rstn) model_reset(i); else model_step(i);

    task automatic cmp_inst(input int i);
        logic        r, busy, g;
        logic [31:0] e_st;
        r    = rstn;
        busy = r && (m_phase[i] == 3'd2);
        g    = m_grant[i];
        e_st = r ? {16'd0, m_tcnt[i], 3'd0, g, 1'b0, m_phase[i]} : 32'd0;
        chk($sformatf("i%0d state", i), st[i], e_st);
        chk($sformatf("i%0d rd_resetn", i), 32'(r_rn[i]), 32'(busy));
        chk($sformatf("i%0d rd_addr", i), r_addr[i], r ? m_addr[i] : 32'd0);
        chk($sformatf("i%0d rd_len", i), r_len[i], r ? m_len[i] : 32'd0);
        chk($sformatf("i%0d rd_next", i), 32'(r_dn[i]), 32'(busy & ch_dn[i][g]));
        chk($sformatf("i%0d dv", i), {30'd0, o_dv1[i], o_dv0[i]},
            {30'd0, busy & g & rd_valid, busy & ~g & rd_valid});
        chk($sformatf("i%0d data0", i), o_d0[i], busy ? rd_data : 32'd0);
        chk($sformatf("i%0d data1", i), o_d1[i], busy ? rd_data : 32'd0);
        chk($sformatf("i%0d done", i), {30'd0, o_done1[i], o_done0[i]}, r ? 32'(m_done[i]) : 32'd0);
        chk($sformatf("i%0d err", i), {30'd0, o_err1[i], o_err0[i]}, r ? 32'(m_err[i]) : 32'd0);
    endtask

    always @(negedge clk)
        for (int i = 0; i < 2; i++) cmp_inst(i);

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int c, input logic v);
        ch_rn[0][c] = v;
        ch_rn[1][c] = v;
    endtask

    initial begin
        int n, b0, b1, seen;
        logic [3:0] ga, gb;
        logic fin;
        rstn = 1'b0;
        ch_addr[0] = '0; ch_addr[1] = '0; ch_len[0] = '0; ch_len[1] = '0;
        ch_rn[0] = '0; ch_rn[1] = '0; ch_dn[0] = 2'b11; ch_dn[1] = 2'b11;
        rd_done = 0; rd_error = 0; rd_valid = 0; rd_data = '0;
        tick(); tick();
        chk("reset state", st[0], 32'd0);
        chk("reset rd_resetn", 32'(r_rn[0]), 32'd0);
        chk("reset done", 32'(o_done0[0] | o_done1[0]), 32'd0);
        rstn = 1'b1;
        tick();

        // single ch0 transfer, 64 beats then done
        ch_addr[0] = 32'h1000; ch_len[0] = 32'd64; set_req(0, 1'b1);
        tick(); chk("t1 arm", st[0], 32'h1);
        tick(); chk("t1 busy", st[0], 32'h2);
        chk("t1 rd_addr", r_addr[0], 32'h1000);
        chk("t1 rd_len", r_len[0], 32'd64);
        chk("t1 rd_resetn", 32'(r_rn[0]), 32'd1);
        b0 = 0; b1 = 0;
        for (int k = 0; k < 64; k++) begin
            rd_valid = 1'b1; rd_data = 32'(k * 3);
            if (k == 5) ch_addr[0] = 32'hBEEF;
            #1;
            b0 += int'(o_dv0[0]); b1 += int'(o_dv1[0]);
            tick();
        end
        chk("t1 addr held", r_addr[0], 32'h1000);
        rd_valid = 1'b0; rd_done = 1'b1;
        tick(); rd_done = 1'b0;
        chk("t1 ch0 beats", 32'(b0), 32'd64);
        chk("t1 ch1 beats", 32'(b1), 32'd0);
        chk("t1 done0", 32'(o_done0[0]), 32'd1);
        chk("t1 done1", 32'(o_done1[0]), 32'd0);
        chk("t1 release", st[0], 32'h4);
        set_req(0, 1'b0);
        tick(); chk("t1 idle", st[0], 32'h0);

        // watchdog
        ch_len[0] = 32'd8; set_req(0, 1'b1);
        tick(); tick();
        rd_valid = 1'b1; tick(); rd_valid = 1'b0;
        n = 0;
        while (!o_err0[0] && n < 40) begin tick(); n++; end
        chk("wd cycles", 32'(n), 32'd16);
        chk("wd count", 32'(st[0][15:8]), 32'd1);
        chk("wd rd_resetn", 32'(r_rn[0]), 32'd0);
        chk("wd release", 32'(st[0][2:0]), 32'd4);
        set_req(0, 1'b0); tick();

        // zero-length ch1, then ch0 normally
        ch_len[1] = 32'd0; set_req(1, 1'b1); seen = 0;
        tick(); seen |= int'(r_rn[0]); chk("z zero", st[0], 32'h113);
        tick(); seen |= int'(r_rn[0]); chk("z done1", 32'(o_done1[0]), 32'd1);
        chk("z release", st[0], 32'h114);
        set_req(1, 1'b0); ch_len[0] = 32'd4; set_req(0, 1'b1);
        tick(); seen |= int'(r_rn[0]); chk("z idle", st[0], 32'h100);
        tick(); tick();
        chk("z rd never up", 32'(seen), 32'd0);
        chk("z ch0 busy", st[0], 32'h102);
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        chk("z ch0 done", 32'(o_done0[0]), 32'd1);
        set_req(0, 1'b0); tick();

        // abort after 10 beats
        ch_len[0] = 32'd64; set_req(0, 1'b1);
        tick(); tick();
        for (int k = 0; k < 10; k++) begin rd_valid = 1'b1; tick(); end
        rd_valid = 1'b0; set_req(0, 1'b0);
        tick();
        chk("ab rd_resetn", 32'(r_rn[0]), 32'd0);
        chk("ab flags", 32'({o_done0[0], o_err0[0]}), 32'd0);
        chk("ab release", 32'(st[0][2:0]), 32'd4);
        tick(); chk("ab idle", 32'(st[0][2:0]), 32'd0);

        // same-cycle done + error
        ch_len[1] = 32'd4; set_req(1, 1'b1);
        tick(); tick();
        rd_done = 1'b1; rd_error = 1'b1; tick(); rd_done = 1'b0; rd_error = 1'b0;
        chk("de err1", 32'(o_err1[0]), 32'd1);
        chk("de done1", 32'(o_done1[0]), 32'd0);
        set_req(1, 1'b0); tick();

        // async reset in BUSY
        ch_addr[0] = 32'h2000; ch_len[0] = 32'd64; set_req(0, 1'b1);
        tick(); tick();
        rd_valid = 1'b1; rd_data = 32'hDEADBEEF; #1;
        chk("ar data bcast", o_d1[0], 32'hDEADBEEF);
        rstn = 1'b0; #1;
        chk("ar state", st[0], 32'd0);
        chk("ar rd_resetn", 32'(r_rn[0]), 32'd0);
        chk("ar rd_addr", r_addr[0], 32'd0);
        chk("ar dv", 32'(o_dv0[0]), 32'd0);
        chk("ar data", o_d0[0], 32'd0);
        rd_valid = 1'b0; set_req(0, 1'b0);
        tick(); rstn = 1'b1; tick();

        // contention: requesters release on done and re-request
        ch_len[0] = 32'd4; ch_len[1] = 32'd4; ch_rn[0] = 2'b11; ch_rn[1] = 2'b11;
        ga = '0; gb = '0;
        for (int r = 0; r < 4; r++) begin
            n = 0;
            while (st[0][2:0] != 3'd2 && n < 10) begin tick(); n++; end
            chk("arb busy", 32'(st[0][2:0]), 32'd2);
            ga[r] = st[0][4]; gb[r] = st[1][4];
            rd_done = 1'b1; tick(); rd_done = 1'b0;
            ch_rn[0][ga[r]] = 1'b0; ch_rn[1][gb[r]] = 1'b0;
            tick();
            ch_rn[0] = 2'b11; ch_rn[1] = 2'b11;
        end
        chk("arb rr grants", 32'(ga), 32'b1010);
        chk("arb pri grants", 32'(gb), 32'b0000);
        ch_rn[0] = '0; ch_rn[1] = '0;
        tick(); tick(); tick();

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                ch_addr[c] = $urandom;
                ch_len[c]  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 100));
            end
            rd_data  = $urandom;
            rd_valid = ($urandom_range(0, 1) == 1);
            rd_done  = ($urandom_range(0, 19) == 0);
            rd_error = ($urandom_range(0, 49) == 0);
            if ((cyc % 300) < 25) begin rd_valid = 0; rd_done = 0; rd_error = 0; end
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < 2; c++) begin
                    if (ch_rn[i][c]) begin
                        fin = c ? (o_done1[i] | o_err1[i]) : (o_done0[i] | o_err0[i]);
                        if (fin) begin
                            if ($urandom_range(0, 1) == 1) ch_rn[i][c] = 1'b0;
                        end else if ($urandom_range(0, 99) == 0) ch_rn[i][c] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) ch_rn[i][c] = 1'b1;
                    ch_dn[i][c] = ($urandom_range(0, 1) == 1);
                end
            rstn = (cyc != 1500);
            tick();
        end
        rstn = 1'b1;
        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
